pulse_interval_meter: RTL and testbench
=======================================

Name: pulse_interval_meter

Overview:
- Measures the number of clk cycles between consecutive rising edges of an asynchronous input pulse.
- Performs the inverse job of our strobe-generating counters: one of those produces a strobe every N cycles, and this block recovers N from a strobe stream.
- Used to measure incoming key/line timing and to check counter-generated strobes.
- Each result goes out through a valid/ready holding register, with overflow and dropped-result flags.

Parameters:
- COUNTWIDTH, 16, width of the interval counter and of the period result.
- SYNC_STAGES, 2, number of synchroniser flops on pulse_in; minimum 2.

Ports:
- clk  in  1  system clock.
- nRST  in  1  asynchronous, active-low reset.
- enable  in  1  measurement enable; level-sensitive.
- pulse_in  in  1  asynchronous input pulse, any width of at least 1 clk period after sync.
- period  out  COUNTWIDTH  captured interval in clk cycles.
- overflow  out  1  the captured period saturated; qualified by period_valid.
- period_valid  out  1  the result register holds an unconsumed result.
- period_ready  in  1  the consumer accepts the result when valid && ready on a clk edge.
- dropped  out  1  one-cycle pulse: a new result was discarded because the register was still full.

Behaviour:
- Reset (nRST low, asynchronous):
  - all synchroniser flops 0; state IDLE; counter 0.
  - period 0, overflow 0, period_valid 0, dropped 0.
- Input conditioning:
  - pulse_in passes through SYNC_STAGES flops; edge = synced && !synced_prev.
  - An edge is detected SYNC_STAGES+1 clk edges after pulse_in rises (2-flop sync gives latency 3).
- States (one-hot or encoded, from the package):
  - IDLE: counter 0, edges ignored. enable=1 -> ARM.
  - ARM: waits for the first edge; nothing is captured. On an edge: counter <= 1, -> MEASURE.
  - MEASURE, on a non-edge cycle: counter <= counter+1, saturating at all-ones (no wrap).
  - MEASURE, on an edge cycle: capture (period=counter, overflow=(counter==all-ones)), then counter <= 1 and stay in MEASURE.
  - enable=0 in any state -> IDLE next cycle; counter cleared. An edge in that same cycle is ignored. The result register is untouched, so a pending result stays valid.
- Period definition: edges detected on cycles t0 and t1 give period = t1 - t0.
- Result register rules:
  - capture && !period_valid: load the result; period_valid=1 next cycle.
  - capture && period_valid && period_ready: load the new result; period_valid stays 1, with no bubble.
  - capture && period_valid && !period_ready: keep the old result; dropped=1 for exactly one cycle.
  - !capture && period_valid && period_ready: period_valid=0 next cycle; period/overflow keep their last value.
  - period and overflow only change on a load.
- Saturation: once the counter hits 2^COUNTWIDTH-1 it holds there until the next edge. That edge reports period=all-ones, overflow=1, and restarts the counter at 1.
- Back-to-back edges: the minimum detectable period is 2, since the synced signal must be low one cycle between edges. period=1 is unreachable.
- Reset mid-measurement: everything returns to reset values immediately and any pending result is lost.
- All outputs are registered; no combinational path from inputs to outputs.

Decomposition:
- Package pim_pkg: state enum (IDLE, ARM, MEASURE) and a result struct {period, overflow}.
- Sub-module sync_edge_detect (params STAGES; ports clk, nRST, async_in, rise): synchroniser plus rising-edge detector, reusable elsewhere.
- The top level holds the FSM, the saturating counter, and the result register/handshake.

Test Plan:
- Reset/idle: nRST low 3 cycles, enable=0, pulse_in toggling -> all outputs 0, period_valid never asserts.
- Basic period: enable=1, COUNTWIDTH=16, pulse_in high 1 cycle every 10 cycles, period_ready=1 -> the first edge only arms. Each later edge gives period=10, overflow=0, period_valid high 1 cycle per result, appearing SYNC_STAGES+2 cycles after pulse_in rises.
- Backpressure: period_ready=0, edges every 8 cycles -> first result period=8 held valid. The second capture gives dropped=1 for 1 cycle with period still 8. Raise ready -> valid drops next cycle.
- Same-cycle consume+capture: time period_ready=1 on the capture cycle with valid=1 -> new period loaded, period_valid stays 1, dropped=0.
- Saturation: COUNTWIDTH=4, edges 40 cycles apart -> period=15, overflow=1. A following 5-cycle gap reports period=5, overflow=0.
- Disable/reset mid-measure: enable=0 after 3 cycles in MEASURE, re-enable, edges 6 apart -> the first post-enable edge only arms, the next gives period=6. Assert nRST during MEASURE -> outputs 0 immediately, asynchronously.

Source files
------------

// File: rtl/pim_pkg.sv
// Shared types for the pulse interval meter: FSM states and the captured result.
package pim_pkg;

  localparam int unsigned PIM_MAX_W = 32;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARM     = 2'd1,
    ST_MEASURE = 2'd2
  } pim_state_e;

  // Period is held at the widest supported width; the top narrows it to COUNTWIDTH.
  typedef struct packed {
    logic [PIM_MAX_W-1:0] period;
    logic                 overflow;
  } pim_result_t;

  function automatic pim_result_t make_result(input logic [PIM_MAX_W-1:0] count,
                                              input logic                 saturated);
    pim_result_t r;
    r.period   = count;
    r.overflow = saturated;
    return r;
  endfunction

endpackage

// File: rtl/sync_edge_detect.sv
// Multi-flop synchroniser followed by a registered rising-edge detector.
module sync_edge_detect #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic nRST,
  input  logic async_in,
  output logic rise
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;

  // Shift the async input through the chain and flag a synced low-to-high step.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      sync_q <= {STAGES{1'b0}};
      prev_q <= 1'b0;
      rise_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], async_in};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
    end
  end

  assign rise = rise_q;

endmodule

// File: rtl/pulse_interval_meter.sv
// Measures clk cycles between successive rising edges of an async pulse and
// hands each result out through a valid/ready holding register.
module pulse_interval_meter #(
  parameter int unsigned COUNTWIDTH  = 16,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  nRST,
  input  logic                  enable,
  input  logic                  pulse_in,
  output logic [COUNTWIDTH-1:0] period,
  output logic                  overflow,
  output logic                  period_valid,
  input  logic                  period_ready,
  output logic                  dropped
);

  import pim_pkg::*;

  localparam logic [COUNTWIDTH-1:0] CNT_ZERO = {COUNTWIDTH{1'b0}};
  localparam logic [COUNTWIDTH-1:0] CNT_ONE  = {{(COUNTWIDTH-1){1'b0}}, 1'b1};
  localparam logic [COUNTWIDTH-1:0] CNT_MAX  = {COUNTWIDTH{1'b1}};

  logic                  rise_s;
  logic                  capture_s;
  pim_state_e            state_q, state_d;
  logic [COUNTWIDTH-1:0] cnt_q, cnt_d;
  pim_result_t           res_q, res_d;
  logic                  valid_q, valid_d;
  logic                  dropped_q, dropped_d;

  sync_edge_detect #(
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clk      (clk),
    .nRST     (nRST),
    .async_in (pulse_in),
    .rise     (rise_s)
  );

  // Measurement FSM with saturating interval counter.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        cnt_d = CNT_ZERO;
        if (enable) state_d = ST_ARM;
        else        state_d = ST_IDLE;
      end
      ST_ARM: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (rise_s) begin
          state_d = ST_MEASURE;
          cnt_d   = CNT_ONE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_MEASURE: begin
        if (!enable) begin
          state_d = ST_IDLE;
          cnt_d   = CNT_ZERO;
        end else if (rise_s) begin
          capture_s = 1'b1;
          cnt_d     = CNT_ONE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_ONE;
        end else begin
          cnt_d = cnt_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = CNT_ZERO;
      end
    endcase
  end

  // Result holding register: a full register refuses a new result unless it is consumed the same cycle.
  always_comb begin
    res_d     = res_q;
    valid_d   = valid_q;
    dropped_d = 1'b0;
    if (capture_s) begin
      if (!valid_q || period_ready) begin
        res_d   = make_result(PIM_MAX_W'(cnt_q), cnt_q == CNT_MAX);
        valid_d = 1'b1;
      end else begin
        dropped_d = 1'b1;
      end
    end else if (valid_q && period_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // State, counter and result registers.
  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q   <= ST_IDLE;
      cnt_q     <= CNT_ZERO;
      res_q     <= make_result({PIM_MAX_W{1'b0}}, 1'b0);
      valid_q   <= 1'b0;
      dropped_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      res_q     <= res_d;
      valid_q   <= valid_d;
      dropped_q <= dropped_d;
    end
  end

  assign period       = COUNTWIDTH'(res_q.period);
  assign overflow     = res_q.overflow;
  assign period_valid = valid_q;
  assign dropped      = dropped_q;

endmodule

// File: tb/tb_pulse_interval_meter.sv
// Directed bench: a 16-bit and a 4-bit meter share one stimulus stream.
module tb_pulse_interval_meter;

  logic        clk;
  logic        nRST;
  logic        enable;
  logic        pulse_in;
  logic        period_ready;

  logic [15:0] period_a;
  logic        overflow_a, valid_a, dropped_a;
  logic [3:0]  period_b;
  logic        overflow_b, valid_b, dropped_b;

  int n_cmp;
  int n_fail;

  pulse_interval_meter #(.COUNTWIDTH(16), .SYNC_STAGES(2)) u_dut (
    .clk          (clk),
    .nRST         (nRST),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (period_a),
    .overflow     (overflow_a),
    .period_valid (valid_a),
    .period_ready (period_ready),
    .dropped      (dropped_a)
  );

  pulse_interval_meter #(.COUNTWIDTH(4), .SYNC_STAGES(2)) u_sat (
    .clk          (clk),
    .nRST         (nRST),
    .enable       (enable),
    .pulse_in     (pulse_in),
    .period       (period_b),
    .overflow     (overflow_b),
    .period_valid (valid_b),
    .period_ready (period_ready),
    .dropped      (dropped_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One-cycle pulse, then look at the outputs on the cycle its result would appear.
  task automatic pulse_and_check(input string tag, input logic exp_v,
                                 input logic [15:0] exp_pa, input logic [3:0] exp_pb,
                                 input logic exp_ob);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(3);
    chk({tag, "/valid_a"},   32'(valid_a),   32'(exp_v));
    chk({tag, "/valid_b"},   32'(valid_b),   32'(exp_v));
    chk({tag, "/dropped_a"}, 32'(dropped_a), 32'd0);
    chk({tag, "/dropped_b"}, 32'(dropped_b), 32'd0);
    if (exp_v) begin
      chk({tag, "/period_a"}, 32'(period_a),   32'(exp_pa));
      chk({tag, "/period_b"}, 32'(period_b),   32'(exp_pb));
      chk({tag, "/ovf_a"},    32'(overflow_a), 32'd0);
      chk({tag, "/ovf_b"},    32'(overflow_b), 32'(exp_ob));
    end
  endtask

  initial begin
    n_cmp        = 0;
    n_fail       = 0;
    nRST         = 1'b0;
    enable       = 1'b0;
    pulse_in     = 1'b0;
    period_ready = 1'b0;

    // Held in reset with pulse activity.
    for (int i = 0; i < 3; i++) begin
      pulse_in = ~pulse_in;
      tick(1);
      chk("rst/period_a",  32'(period_a),   32'd0);
      chk("rst/ovf_a",     32'(overflow_a), 32'd0);
      chk("rst/valid_a",   32'(valid_a),    32'd0);
      chk("rst/dropped_a", 32'(dropped_a),  32'd0);
      chk("rst/valid_b",   32'(valid_b),    32'd0);
    end
    nRST = 1'b1;

    // Out of reset but disabled: edges must be ignored.
    for (int i = 0; i < 12; i++) begin
      pulse_in = ~pulse_in;
      tick(1);
      chk("idle/valid_a", 32'(valid_a), 32'd0);
      chk("idle/valid_b", 32'(valid_b), 32'd0);
    end
    pulse_in = 1'b0;
    tick(4);

    // Basic period of 10 with ready high.
    enable       = 1'b1;
    period_ready = 1'b1;
    tick(2);
    pulse_and_check("arm", 1'b0, 16'd0, 4'd0, 1'b0);
    tick(6);
    pulse_and_check("p10a", 1'b1, 16'd10, 4'd10, 1'b0);
    tick(1);
    chk("p10a/consumed_a", 32'(valid_a), 32'd0);
    chk("p10a/consumed_b", 32'(valid_b), 32'd0);
    tick(5);
    pulse_and_check("p10b", 1'b1, 16'd10, 4'd10, 1'b0);
    tick(4);

    // Backpressure: first result held, next (period 9) dropped.
    period_ready = 1'b0;
    pulse_and_check("bp8", 1'b1, 16'd8, 4'd8, 1'b0);
    tick(5);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(3);
    chk("drop/dropped_a", 32'(dropped_a), 32'd1);
    chk("drop/dropped_b", 32'(dropped_b), 32'd1);
    chk("drop/valid_a",   32'(valid_a),   32'd1);
    chk("drop/period_a",  32'(period_a),  32'd8);
    tick(1);
    chk("drop1/dropped_a", 32'(dropped_a), 32'd0);
    chk("drop1/valid_a",   32'(valid_a),   32'd1);
    chk("drop1/period_a",  32'(period_a),  32'd8);
    period_ready = 1'b1;
    tick(1);
    chk("rel/valid_a",  32'(valid_a),  32'd0);
    chk("rel/period_a", 32'(period_a), 32'd8);

    // Same-cycle consume and capture.
    period_ready = 1'b0;
    tick(2);
    pulse_and_check("sc8", 1'b1, 16'd8, 4'd8, 1'b0);
    tick(2);
    pulse_in = 1'b1;
    tick(1);
    pulse_in = 1'b0;
    tick(2);
    chk("sc/pre_valid_a",  32'(valid_a),  32'd1);
    chk("sc/pre_period_a", 32'(period_a), 32'd8);
    period_ready = 1'b1;
    tick(1);
    chk("sc/valid_a",   32'(valid_a),   32'd1);
    chk("sc/period_a",  32'(period_a),  32'd6);
    chk("sc/period_b",  32'(period_b),  32'd6);
    chk("sc/dropped_a", 32'(dropped_a), 32'd0);
    tick(1);
    chk("sc/after_valid_a", 32'(valid_a), 32'd0);

    // Saturation on the 4-bit meter, then a short gap.
    tick(35);
    pulse_and_check("sat40", 1'b1, 16'd40, 4'd15, 1'b1);
    tick(1);
    pulse_and_check("gap5", 1'b1, 16'd5, 4'd5, 1'b0);

    // Disable mid-measure, re-enable: first edge only re-arms.
    tick(3);
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    pulse_and_check("rearm", 1'b0, 16'd0, 4'd0, 1'b0);
    tick(2);
    pulse_and_check("p6", 1'b1, 16'd6, 4'd6, 1'b0);

    // Asynchronous reset with a pending result.
    period_ready = 1'b0;
    tick(2);
    chk("pend/valid_a", 32'(valid_a), 32'd1);
    #2;
    nRST = 1'b0;
    #1;
    chk("arst/period_a",  32'(period_a),   32'd0);
    chk("arst/ovf_a",     32'(overflow_a), 32'd0);
    chk("arst/valid_a",   32'(valid_a),    32'd0);
    chk("arst/dropped_a", 32'(dropped_a),  32'd0);
    chk("arst/valid_b",   32'(valid_b),    32'd0);
    tick(2);
    nRST = 1'b1;
    tick(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
